// File: rtl/bada_inst_seq.sv
// rtl/bada_inst_seq.sv - tile-request queue and LOAD/MAC/DRAIN instruction sequencer for BADA_array
module bada_inst_seq #(
  parameter int INST_WIDTH  = 32,
  parameter int MAC_LATENCY = 4,
  parameter int NUM_PASS    = 4,
  parameter int Q_DEPTH     = 2,
  parameter int ACC_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_en,
  input  logic                  data_last,
  output logic                  data_rdy,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_vld,
  output logic                  out_vld,
  output logic                  busy,
  output logic                  err_ovf
);

  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(Q_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(Q_DEPTH);
  localparam logic [7:0]    LAST_CYC  = 8'(MAC_LATENCY - 1);
  localparam logic [3:0]    LAST_PASS = 4'(NUM_PASS - 1);

  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_MAC   = 4'd2;
  localparam logic [3:0] OP_DRAIN = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [31:0]     inst_w;
  logic [7:0]      tile_id;
  logic            grp_start;
  logic            last_q;
  logic [3:0]      pass_q;
  logic [7:0]      cyc_q;

  logic [Q_DEPTH-1:0] q_bits;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic       push;
  logic       avail;
  logic       go_load;
  logic       wr_en;
  logic       rd_en;
  logic       head_last;
  logic       pop_last;
  logic       mac_end;
  logic [7:0] load_tile;
  logic [3:0] pass_nx;
  logic [7:0] cyc_nx;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] pass,
                                      input logic [7:0] cyc, input logic [7:0] tile,
                                      input logic clr);
    return {op, pass, cyc, tile, clr, 7'd0};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign data_rdy = !reset && (count < CNT_FULL);
  assign push     = data_en && data_rdy;
  assign avail    = (count != '0) || push;

  // An empty queue lets a request arriving this cycle go straight to LOAD.
  assign head_last = (count != '0) ? q_bits[rd_ptr] : data_last;
  assign pop_last  = (ACC_MODE != 0) ? head_last : 1'b1;

  assign mac_end = (state == S_MAC) && (pass_q == LAST_PASS) && (cyc_q == LAST_CYC);

  always_comb begin
    go_load = 1'b0;
    case (state)
      S_IDLE:  go_load = avail;
      S_MAC:   go_load = mac_end && !last_q && avail;
      S_DONE:  go_load = avail;
      default: go_load = 1'b0;
    endcase
  end

  assign wr_en = push && !(go_load && (count == '0));
  assign rd_en = go_load && (count != '0);

  // A non-last tile bumps the tile id on its way out of MAC.
  assign load_tile = (state == S_MAC) ? tile_id + 8'd1 : tile_id;

  always_comb begin
    pass_nx = pass_q;
    cyc_nx  = cyc_q + 8'd1;
    if (cyc_q == LAST_CYC) begin
      pass_nx = pass_q + 4'd1;
      cyc_nx  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) q_bits[wr_ptr] <= data_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (data_en && !data_rdy) err_ovf <= 1'b1;
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      inst_w    <= 32'd0;
      out_vld   <= 1'b0;
      tile_id   <= 8'd0;
      grp_start <= 1'b1;
      last_q    <= 1'b0;
      pass_q    <= 4'd0;
      cyc_q     <= 8'd0;
    end else begin
      out_vld <= 1'b0;
      if (go_load) begin
        state     <= S_LOAD;
        inst_w    <= enc(OP_LOAD, 4'd0, 8'd0, load_tile, grp_start);
        tile_id   <= load_tile;
        grp_start <= 1'b0;
        last_q    <= pop_last;
      end else begin
        case (state)
          S_IDLE: begin
            inst_w <= 32'd0;
          end
          S_LOAD: begin
            state  <= S_MAC;
            pass_q <= 4'd0;
            cyc_q  <= 8'd0;
            inst_w <= enc(OP_MAC, 4'd0, 8'd0, tile_id, 1'b0);
          end
          S_MAC: begin
            if (mac_end) begin
              if (last_q) begin
                state  <= S_DRAIN;
                cyc_q  <= 8'd0;
                inst_w <= enc(OP_DRAIN, 4'd0, 8'd0, tile_id, 1'b0);
              end else begin
                state   <= S_IDLE;
                tile_id <= tile_id + 8'd1;
                inst_w  <= 32'd0;
              end
            end else begin
              pass_q <= pass_nx;
              cyc_q  <= cyc_nx;
              inst_w <= enc(OP_MAC, pass_nx, cyc_nx, tile_id, 1'b0);
            end
          end
          S_DRAIN: begin
            if (cyc_q == LAST_CYC) begin
              // Tile id and group start move on here so the DONE cycle can LOAD directly.
              state     <= S_DONE;
              inst_w    <= 32'd0;
              out_vld   <= 1'b1;
              tile_id   <= tile_id + 8'd1;
              grp_start <= 1'b1;
            end else begin
              cyc_q  <= cyc_q + 8'd1;
              inst_w <= enc(OP_DRAIN, 4'd0, cyc_q + 8'd1, tile_id, 1'b0);
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            inst_w <= 32'd0;
          end
          default: begin
            state  <= S_IDLE;
            inst_w <= 32'd0;
          end
        endcase
      end
    end
  end

  assign inst     = INST_WIDTH'(inst_w);
  assign inst_vld = (inst_w[31:28] != 4'd0);
  assign busy     = (state != S_IDLE) || (count != '0);

endmodule

// File: doc/bada_inst_seq.md
Name: bada_inst_seq

Overview:
- Parametrised successor to the fixed-latency instruction controller that feeds BADA_array.
- Accepts tile requests through a ready/valid handshake and queues them.
- For each tile, emits a sequenced 32-bit instruction stream: LOAD, then NUM_PASS×MAC_LATENCY MAC cycles, then an optional DRAIN.
- Adds a cross-tile accumulation mode, a completion strobe and overflow detection.

Parameters:
- INST_WIDTH, 32, instruction width; must be ≥32; bits above [31:0] are driven 0.
- MAC_LATENCY, 4, MAC pipeline depth in cycles; legal range 1..255.
- NUM_PASS, 4, MAC passes per tile (Booth/precision split); legal range 1..15.
- Q_DEPTH, 2, pending-request queue depth; must be ≥1.
- ACC_MODE, 0, accumulation mode: 0 = drain every tile; 1 = accumulate until a tile flagged last.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- data_en, in, 1, tile request valid; accepted when data_rdy=1.
- data_last, in, 1, last tile of an accumulation group; sampled with data_en; ignored when ACC_MODE=0.
- data_rdy, out, 1, queue can accept a request.
- inst, out, INST_WIDTH, registered instruction to BADA_array.
- inst_vld, out, 1, inst opcode != NOP.
- out_vld, out, 1, one-cycle pulse: BADA_array odata is valid.
- busy, out, 1, FSM not IDLE, or queue non-empty.
- err_ovf, out, 1, sticky: data_en seen while data_rdy=0.

Behaviour:
- Instruction encoding:
  - [31:28] opcode: 0 NOP, 1 LOAD, 2 MAC, 4 DRAIN.
  - [27:24] pass index.
  - [23:16] cycle within pass (or within drain).
  - [15:8] tile id.
  - [7] acc_clr (LOAD only).
  - [6:0] = 0.
- Reset (reset=1 at a clock edge): next cycle inst=0, inst_vld=0, out_vld=0, busy=0, err_ovf=0, tile id=0, queue empty, group-start flag=1, FSM=IDLE. data_rdy=0 while reset is high. Reset mid-operation aborts the tile with no out_vld.
- Queue: FIFO of Q_DEPTH entries, each holding a last bit.
  - data_rdy = (count < Q_DEPTH) and not reset.
  - A push and a pop in the same cycle are legal; count is unchanged.
  - data_en while data_rdy=0 is dropped and sets err_ovf (cleared only by reset).
- FSM states:
  - IDLE: inst=NOP. If the queue is non-empty, go to LOAD next cycle.
  - LOAD (1 cycle): pop the queue.
    - inst = LOAD, tile id, acc_clr = group-start flag.
    - Set group-start flag = 0; latch the popped last bit (forced 1 when ACC_MODE=0).
  - MAC (NUM_PASS×MAC_LATENCY cycles, k = 0..):
    - pass = k / MAC_LATENCY; cyc = k % MAC_LATENCY.
    - After the final MAC cycle: if last=1 go to DRAIN. Otherwise increment tile id, then go to LOAD if the queue is non-empty, else IDLE.
  - DRAIN (MAC_LATENCY cycles): cyc = 0..MAC_LATENCY-1; pass field = 0; then go to DONE.
  - DONE (1 cycle): inst=NOP, out_vld=1, group-start flag=1, tile id increments (wraps 255→0). Then go to LOAD if the queue is non-empty, else IDLE.
- Latency from idle, request accepted at cycle 0:
  - LOAD at cycle 1.
  - MAC at cycles 2..1+N·L.
  - DRAIN at cycles 2+N·L..1+N·L+L.
  - out_vld at cycle 2+N·L+L (defaults: 22).
- A request accepted during a DONE cycle is eligible for LOAD in the next cycle.
- ACC_MODE=1: a non-last tile in the queue follows its predecessor's last MAC cycle with no bubble.

Test Plan:
- Defaults, single data_en at cycle 0:
  - inst=0x10000080 at cycle 1.
  - inst=0x21020000 at cycle 8.
  - DRAIN 0x40000000..0x40030000 at cycles 18–21.
  - out_vld=1 only at cycle 22; busy falls at cycle 23.
- Defaults, data_en held cycles 0–3:
  - Requests at cycles 0, 1, 2 accepted; the cycle-3 request is dropped and err_ovf=1 from cycle 4.
  - Tile 1 LOAD 0x10000180 at cycle 23, out_vld at 44.
  - Tile 2 LOAD at 45, out_vld at 66.
- ACC_MODE=1, data_en at cycles 0, 1, 2 with data_last=0, 0, 1:
  - LOADs at cycles 1, 18, 35; acc_clr set only on the first.
  - No DRAIN until cycles 52–55; a single out_vld at cycle 56.
  - A following request gets acc_clr=1.
- Reset mid-MAC:
  - data_en at cycle 0, reset=1 at cycle 10 → from cycle 11 all outputs 0 and no out_vld.
  - After reset is released, a new data_en gives LOAD 0x10000080 (tile 0).
- MAC_LATENCY=1, NUM_PASS=1: data_en at cycle 0 → LOAD at cycle 1, MAC at 2, DRAIN at 3, out_vld at 4.
- Tile-id wrap: 256 sequential tiles → the 257th LOAD carries tile id 0x00.
